batch_streamer: RTL

BATCH_STREAMER -- requirements
Module: batch_streamer

---
 rtl/batch_streamer_if.sv | 37 +++
 rtl/batch_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/batch_streamer_if.sv
// batch_streamer_if
// Groups the streamer's request, consumer and sample-memory signals.
//   start      : one-cycle request to stream one batch
//   readEn     : consumer ready
//   readData   : current word (IEEE-754 single)
//   data_valid : readData holds an untransferred word
//   mem_rd     : sample-memory read strobe
//   mem_addr   : sample-memory read address (ADDR_W bits)
//   mem_data   : sample-memory read data, valid one cycle after mem_rd
//   busy       : batch in progress
//   done       : one-cycle pulse after the last word transfers
//   checksum   : running 32-bit word sum (0 when the checksum build is off)
// master = streamer side, slave = requester/consumer/memory side.
interface batch_streamer_if #(
  parameter int ADDR_W = 17
) ();
  logic              start;
  logic              readEn;
  logic [31:0]       readData;
  logic              data_valid;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  modport master (
    input  start, readEn, mem_data,
    output readData, data_valid, mem_rd, mem_addr, busy, done, checksum
  );

  modport slave (
    output start, readEn, mem_data,
    input  readData, data_valid, mem_rd, mem_addr, busy, done, checksum
  );
endinterface

// File: rtl/batch_streamer.sv
// batch_streamer
// Streams one training batch from a sample memory: first the M x N feature
// matrix X (address i*N+j), then the M x K label matrix y (address
// Y_BASE+i*K+k), both row-major, through a 2-entry output FIFO to a consumer.
// Ports:
//   clk  : single clock (also the consumer's read clock)
//   rst  : synchronous active-high reset
//   bus  : batch_streamer_if.master (start/readEn/readData/data_valid,
//          mem_rd/mem_addr/mem_data, busy/done/checksum)
// Optional feature: define STREAMER_CHECKSUM_EN to build the running checksum
// (cleared on an accepted start, adds every transferred word modulo 2^32).
// Without the macro checksum is tied to 0 and no adder exists.
module batch_streamer #(
  parameter int M      = 100,
  parameter int N      = 784,
  parameter int K      = 10,
  parameter int ADDR_W = 17,
  parameter int Y_BASE = M * N
) (
  input  logic             clk,
  input  logic             rst,
  batch_streamer_if.master bus
);

  localparam int CMAX  = (N > K) ? N : K;
  localparam int ROW_W = $clog2(M + 1);
  localparam int COL_W = $clog2(CMAX + 1);

  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(M - 1);
  localparam logic [COL_W-1:0]  COL_LAST_X = COL_W'(N - 1);
  localparam logic [COL_W-1:0]  COL_LAST_Y = COL_W'(K - 1);
  localparam logic [ADDR_W-1:0] Y_ADDR     = ADDR_W'(Y_BASE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    X_PHASE = 2'd1,
    Y_PHASE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;   // read issued last cycle; data on mem_data now
  logic [31:0]       ent0_q, ent0_d;   // FIFO head, drives readData
  logic [31:0]       ent1_q, ent1_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;

  logic              pop_s;
  logic              accept_s;
  logic              issue_s;
  logic              last_col_s;
  logic              last_row_s;
  logic [2:0]        fill_s;

  assign pop_s    = v0_q & bus.readEn;
  // A start on the cycle done pulses is dropped, so done_q gates acceptance.
  assign accept_s = (state_q == IDLE) & bus.start & ~done_q;

  // Slots committed once this cycle's pop and the pending return settle.
  // Counting the pop is what lets a read issue every cycle while streaming.
  assign fill_s  = {2'b00, v0_q} + {2'b00, v1_q} + {2'b00, pend_q} - {2'b00, pop_s};
  assign issue_s = ((state_q == X_PHASE) || (state_q == Y_PHASE)) && (fill_s < 3'd2);

  assign last_col_s = (state_q == Y_PHASE) ? (col_q == COL_LAST_Y) : (col_q == COL_LAST_X);
  assign last_row_s = (row_q == ROW_LAST);

  // Sequencer next state: phase, row/column counters, address, busy/done.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = X_PHASE;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      X_PHASE, Y_PHASE: begin
        if (issue_s) begin
          // Row-major layout makes the address a plain increment.
          addr_d = addr_q + ADDR_W'(1);
          if (last_col_s) begin
            col_d = '0;
            if (last_row_s) begin
              row_d = '0;
              if (state_q == X_PHASE) begin
                state_d = Y_PHASE;
                addr_d  = Y_ADDR;
              end else begin
                state_d = DRAIN;
              end
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      DRAIN: begin
        // Finish once nothing is pending and the last word leaves this edge.
        if (!pend_q && !v1_q && (!v0_q || pop_s)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO next state: pop shifts the tail to the head, then the return lands
  // in the first free slot (second slot when the consumer is stalled).
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    pend_d = issue_s;
    if (pop_s) begin
      ent0_d = ent1_q;
      v0_d   = v1_q;
      v1_d   = 1'b0;
    end else begin
      ent0_d = ent0_q;
    end
    if (pend_q) begin
      if (!v0_d) begin
        ent0_d = bus.mem_data;
        v0_d   = 1'b1;
      end else begin
        ent1_d = bus.mem_data;
        v1_d   = 1'b1;
      end
    end else begin
      ent1_d = ent1_d;
    end
  end

  // State registers; reset also drops any return still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      ent0_q  <= 32'd0;
      ent1_q  <= 32'd0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

`ifdef STREAMER_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // Checksum next value: clear on accepted start, accumulate each transfer.
  always_comb begin
    cks_d = cks_q;
    if (accept_s) begin
      cks_d = 32'd0;
    end else if (pop_s) begin
      cks_d = cks_q + ent0_q;
    end else begin
      cks_d = cks_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cks_q <= 32'd0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign bus.checksum = cks_q;
`else
  assign bus.checksum = 32'd0;
`endif

  // mem_rd must follow the same-cycle pop to keep one word per cycle, so it
  // is the only output not taken straight from a flop.
  assign bus.mem_rd     = issue_s;
  assign bus.mem_addr   = addr_q;
  assign bus.readData   = ent0_q;
  assign bus.data_valid = v0_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
